// File: rtl/z_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : z_core_pkg
//  Description : Shared z_core definitions: register-dump FSM state type and
//                architectural register-index constants.
//  Revision    : 1.0  initial release
// ============================================================================
package z_core_pkg;

    // Register-dump sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    // Architectural register indices
    localparam int unsigned X0    = 0;   // hard-wired zero register
    localparam int unsigned XLAST = 31;  // highest register index

endpackage : z_core_pkg
`default_nettype wire

// File: rtl/z_core_reg_dump.sv
`default_nettype none
// ============================================================================
//  Module      : z_core_reg_dump
//  Description : Walks an inclusive range of register-file indices through
//                the reg file rs1 read port and streams each captured value
//                out over a valid/ready interface, one word per two cycles.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   clock, all state on rising edge
//    reset      in   asynchronous active-low reset
//    start      in   dump request, sampled only while idle
//    abort      in   terminate a dump in progress
//    first_reg  in   first index of the range (latched on accept)
//    last_reg   in   last index of the range, inclusive (latched on accept)
//    rs_addr    out  registered read address to reg file rs1
//    rs_data    in   asynchronous read data from reg file rs1
//    out_valid  out  out_data/out_idx/out_last valid
//    out_ready  in   consumer accepts when out_valid & out_ready
//    out_data   out  captured register value
//    out_idx    out  index of out_data
//    out_last   out  final word of the range
//    busy       out  sequencer not idle
//    done       out  one-cycle pulse after the final word is accepted
//    err        out  one-cycle pulse when a start is rejected (empty range)
// ============================================================================
module z_core_reg_dump
    import z_core_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SKIP_X0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0] rs_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    dump_state_t       r_state;
    dump_state_t       w_next_state;

    logic [ADDR_W-1:0] r_rs_addr;
    logic [ADDR_W-1:0] r_last;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_idx;
    logic              r_out_last;
    logic              r_out_valid;
    logic              r_err;

    logic [ADDR_W-1:0] w_eff_first;
    logic              w_handshake;
    logic              w_load;
    logic              w_reject;
    logic              w_capture;
    logic              w_advance;
    logic              w_release;

    // x0 is hard-wired to zero, so a range starting there begins at x1
    always_comb begin
        w_eff_first = first_reg;
        if ((SKIP_X0 != 0) && (first_reg == ADDR_W'(X0))) begin
            w_eff_first = ADDR_W'(1);
        end
    end

    assign w_handshake = r_out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_reject     = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_release    = 1'b0;
        busy         = (r_state != ST_IDLE);
        done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // abort outranks a simultaneous start
                if (start && !abort) begin
                    if (w_eff_first > last_reg) begin
                        w_reject = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_release    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_handshake) begin
                    w_release = 1'b1;
                    // increment only below the last index, so 31 never wraps
                    if (r_out_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                done         = !abort;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs_addr   <= '0;
            r_last      <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_reject;

            if (w_load) begin
                r_rs_addr <= w_eff_first;
                r_last    <= last_reg;
            end else if (w_advance) begin
                r_rs_addr <= r_rs_addr + ADDR_W'(1);
            end

            // Word is captured once in READ; later reg file writes do not
            // disturb the held copy.
            if (w_capture) begin
                r_out_data  <= rs_data;
                r_out_idx   <= r_rs_addr;
                r_out_last  <= (r_rs_addr == r_last);
                r_out_valid <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rs_addr   = r_rs_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule : z_core_reg_dump
`default_nettype wire

// File: doc/z_core_reg_dump.md
Z_CORE_REG_DUMP -- requirements
Module: z_core_reg_dump

Interface
REQ-001 Parameter DATA_W, 32, register data width.
REQ-002 Parameter ADDR_W, 5, register index width.
REQ-003 Parameter SKIP_X0, 1, when 1 index 0 is never emitted.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 abort  in  1  terminates a dump in progress.
REQ-008 first_reg  in  ADDR_W  first index of range; latched at accepted start.
REQ-009 last_reg  in  ADDR_W  last index of range, inclusive; latched at accepted start.
REQ-010 rs_addr  out  ADDR_W  read address to z_core_reg_file rs1 port (registered).
REQ-011 rs_data  in  DATA_W  asynchronous read data from z_core_reg_file rs1_out.
REQ-012 out_valid  out  1  out_data/out_idx/out_last valid.
REQ-013 out_ready  in  1  consumer accepts word when out_valid & out_ready.
REQ-014 out_data  out  DATA_W  captured register value.
REQ-015 out_idx  out  ADDR_W  index of out_data.
REQ-016 out_last  out  1  high with final word of range.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 done  out  1  one-cycle pulse after final word accepted.
REQ-019 err  out  1  one-cycle pulse when start rejected for an empty range.

Function
REQ-020 FSM states IDLE, READ, HOLD, DONE; encoding free.
REQ-021 IDLE: on start, effective first = (SKIP_X0 && first_reg==0) ? 1 : first_reg.
REQ-022 IDLE: if effective first > last_reg, pulse err next cycle, remain IDLE, no rs_addr change.
REQ-023 IDLE: otherwise rs_addr <= effective first, latch last_reg, go READ.
REQ-024 READ (one cycle): out_data <= rs_data, out_idx <= rs_addr, out_last <= (rs_addr==last), out_valid <= 1, go HOLD.
REQ-025 HOLD: outputs held stable while out_valid & !out_ready.
REQ-026 HOLD: on handshake with out_last=0, out_valid <= 0, rs_addr <= rs_addr+1, go READ.
REQ-027 HOLD: on handshake with out_last=1, out_valid <= 0, go DONE.
REQ-028 DONE: done=1 for exactly one cycle, go IDLE.
REQ-029 Latency: start at edge N -> out_valid high after edge N+2; max throughput one word per 2 cycles.
REQ-030 last_reg = 31 (all ones): index never wraps; out_last terminates at 31.
REQ-031 Snapshot: out_data reflects reg file contents at READ cycle; later writes not reflected in held word.
REQ-032 start outside IDLE ignored; first_reg/last_reg changes after accept ignored.
REQ-033 abort in READ/HOLD/DONE: next cycle IDLE, out_valid=0, no done, no err.
REQ-034 abort and start same cycle in IDLE: abort wins, start ignored.

Reset
REQ-035 reset low: state IDLE, rs_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0, err=0, busy=0, immediately and asynchronously.
REQ-036 reset mid-dump discards transfer; no done pulse on release.

Structure
REQ-037 FSM state typedef and register-index constants (X0=0, XLAST=31) in shared z_core package.
REQ-038 Single module, no sub-modules; instantiated alongside z_core_reg_file, driving its rs1 port.

Verification
REQ-039 Reg file x5=15, x8=25; start first=5,last=8, out_ready=1 -> words (5,15),(6,x6),(7,x7),(8,25,last), then done pulse.
REQ-040 first=0,last=2, SKIP_X0=1 -> first word idx 1; exactly 2 words; done once.
REQ-041 first=9,last=3 -> err pulse one cycle, busy stays 0, no out_valid.
REQ-042 out_ready low 5 cycles during idx 8 -> out_data=25, out_idx=8 stable; write x8=99 meanwhile -> still 25.
REQ-043 first=30,last=31 -> words 30,31 with out_last on 31, no wrap to 0.
REQ-044 Abort (or reset low) during HOLD of idx 6 -> out_valid 0 next cycle, IDLE, no done; new start succeeds.
